// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key-schedule permutation tables, shift schedule and state encoding
package des_pkg;

    // Entries use DES numbering: bit 1 is the MSB of the source vector.
    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT_TBL [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GEN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - combinational PC-2 compression of the 56-bit {C,D} register into a subkey
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] subkey
);

    genvar i;
    generate
        for (i = 0; i < 48; i++) begin : g_bit
            assign subkey[47-i] = cd[56 - PC2_TBL[i]];
        end
    endgenerate

endmodule

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - sequential DES key schedule producing 16 registered subkeys
module des_key_schedule
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [63:0] key,
    input  logic        decrypt,
    output logic        keys_valid,
    output logic [47:0] subkey_0,
    output logic [47:0] subkey_1,
    output logic [47:0] subkey_2,
    output logic [47:0] subkey_3,
    output logic [47:0] subkey_4,
    output logic [47:0] subkey_5,
    output logic [47:0] subkey_6,
    output logic [47:0] subkey_7,
    output logic [47:0] subkey_8,
    output logic [47:0] subkey_9,
    output logic [47:0] subkey_10,
    output logic [47:0] subkey_11,
    output logic [47:0] subkey_12,
    output logic [47:0] subkey_13,
    output logic [47:0] subkey_14,
    output logic [47:0] subkey_15
);

    logic [1:0]  state;
    logic [27:0] c_r, d_r;
    logic [27:0] c_rot, d_rot;
    logic [3:0]  rnd;
    logic [3:0]  slot;
    logic        dec_r;
    logic [55:0] pc1_key;
    logic [47:0] pc2_out;
    logic [47:0] sk [16];
    logic        unused_parity;

    assign key_ready = (state != ST_GEN);
    assign unused_parity = ^{key[56], key[48], key[40], key[32],
                             key[24], key[16], key[8], key[0]};

    always_comb begin
        pc1_key = '0;
        for (int i = 0; i < 56; i++) begin
            pc1_key[55-i] = key[64 - PC1_TBL[i]];
        end
    end

    always_comb begin
        if (SHIFT_TBL[rnd] == 2'd2) begin
            c_rot = {c_r[25:0], c_r[27:26]};
            d_rot = {d_r[25:0], d_r[27:26]};
        end else begin
            c_rot = {c_r[26:0], c_r[27]};
            d_rot = {d_r[26:0], d_r[27]};
        end
    end

    // Decryption fills the slots back-to-front so the network can stay unchanged.
    assign slot = dec_r ? (4'd15 - rnd) : rnd;

    des_pc2 u_pc2 (
        .cd     ({c_rot, d_rot}),
        .subkey (pc2_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            c_r        <= '0;
            d_r        <= '0;
            rnd        <= '0;
            dec_r      <= 1'b0;
            keys_valid <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                sk[i] <= '0;
            end
        end else if (key_valid && key_ready) begin
            c_r        <= pc1_key[55:28];
            d_r        <= pc1_key[27:0];
            dec_r      <= decrypt;
            rnd        <= '0;
            keys_valid <= 1'b0;
            state      <= ST_GEN;
        end else if (state == ST_GEN) begin
            c_r      <= c_rot;
            d_r      <= d_rot;
            sk[slot] <= pc2_out;
            rnd      <= rnd + 4'd1;
            if (rnd == 4'd15) begin
                state      <= ST_DONE;
                keys_valid <= 1'b1;
            end
        end
    end

    assign subkey_0  = sk[0];
    assign subkey_1  = sk[1];
    assign subkey_2  = sk[2];
    assign subkey_3  = sk[3];
    assign subkey_4  = sk[4];
    assign subkey_5  = sk[5];
    assign subkey_6  = sk[6];
    assign subkey_7  = sk[7];
    assign subkey_8  = sk[8];
    assign subkey_9  = sk[9];
    assign subkey_10 = sk[10];
    assign subkey_11 = sk[11];
    assign subkey_12 = sk[12];
    assign subkey_13 = sk[13];
    assign subkey_14 = sk[14];
    assign subkey_15 = sk[15];

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - randomized self-checking bench for des_key_schedule
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic        decrypt = 1'b0;
    logic [63:0] key = '0;
    logic        key_ready;
    logic        keys_valid;
    logic [47:0] so [16];

    int total = 0;
    int bad = 0;

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] K1P = 64'h133457799BBCDFF0;
    localparam logic [63:0] KW = 64'h0101010101010101;
    localparam logic [47:0] SK_FIRST = 48'h1B02EFFC7072;
    localparam logic [47:0] SK_LAST = 48'hCB3D8B0E17F5;

    int p1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                    10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                    63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                    14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int p2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                    16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                    44,49,39,56,34,53, 46,42,50,36,29,32};

    always #5 clk = ~clk;

    des_key_schedule dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key        (key),
        .decrypt    (decrypt),
        .keys_valid (keys_valid),
        .subkey_0   (so[0]),
        .subkey_1   (so[1]),
        .subkey_2   (so[2]),
        .subkey_3   (so[3]),
        .subkey_4   (so[4]),
        .subkey_5   (so[5]),
        .subkey_6   (so[6]),
        .subkey_7   (so[7]),
        .subkey_8   (so[8]),
        .subkey_9   (so[9]),
        .subkey_10  (so[10]),
        .subkey_11  (so[11]),
        .subkey_12  (so[12]),
        .subkey_13  (so[13]),
        .subkey_14  (so[14]),
        .subkey_15  (so[15])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Subkey of round r straight from the DES rules: cumulative rotation, no register stepping.
    function automatic logic [47:0] model_subkey(input logic [63:0] k, input int r);
        int tot = 0;
        bit kb [64];
        bit cd [56];
        bit rc [56];
        logic [47:0] o;
        for (int i = 0; i <= r; i++) tot += (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
        for (int i = 0; i < 64; i++) kb[i] = k[63-i];
        for (int i = 0; i < 56; i++) cd[i] = kb[p1[i]-1];
        for (int i = 0; i < 28; i++) begin
            rc[i]    = cd[(i + tot) % 28];
            rc[28+i] = cd[28 + (i + tot) % 28];
        end
        for (int i = 0; i < 48; i++) o[47-i] = rc[p2[i]-1];
        return o;
    endfunction

    bit          m_busy = 0;
    int          m_cnt = 0;
    bit          m_valid = 0;
    bit          m_known = 1;
    logic [47:0] m_sk [16];
    logic [47:0] m_pend [16];

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_cnt = 0; m_valid = 0; m_known = 1;
            for (int r = 0; r < 16; r++) m_sk[r] = '0;
        end else if (key_valid && !m_busy) begin
            m_busy = 1; m_cnt = 0; m_valid = 0; m_known = 0;
            for (int r = 0; r < 16; r++) m_pend[decrypt ? 15 - r : r] = model_subkey(key, r);
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == 16) begin
                m_busy = 0; m_valid = 1; m_known = 1;
                for (int r = 0; r < 16; r++) m_sk[r] = m_pend[r];
            end
        end
    end

    always @(negedge clk) begin
        chk("key_ready", {63'b0, key_ready}, {63'b0, !m_busy});
        chk("keys_valid", {63'b0, keys_valid}, {63'b0, m_valid});
        if (m_known) begin
            for (int r = 0; r < 16; r++) chk($sformatf("subkey_%0d", r), so[r], m_sk[r]);
        end
    end

    task automatic accept(input logic [63:0] k, input bit d);
        @(negedge clk);
        key = k; decrypt = d; key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!keys_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!keys_valid) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int n;
        logic [63:0] kr;
        chk("model_k1_first", model_subkey(K1, 0), SK_FIRST);
        chk("model_k1_last", model_subkey(K1, 15), SK_LAST);
        repeat (2) @(negedge clk);
        chk("reset_ready", {63'b0, key_ready}, 64'd1);
        chk("reset_sk7", so[7], 64'd0);
        rst = 1'b0;

        accept(K1, 1'b0);
        wait_done(n);
        chk("t1_latency", n, 16);
        chk("t1_sk0", so[0], SK_FIRST);
        chk("t1_sk15", so[15], SK_LAST);

        accept(K1, 1'b1);
        wait_done(n);
        chk("t2_sk0", so[0], SK_LAST);
        chk("t2_sk15", so[15], SK_FIRST);

        accept(K1P, 1'b0);
        wait_done(n);
        chk("t3_sk0", so[0], SK_FIRST);
        chk("t3_sk15", so[15], SK_LAST);

        accept(KW, 1'b0);
        wait_done(n);
        for (int r = 0; r < 16; r++) chk($sformatf("weak_sk%0d", r), so[r], 64'd0);

        accept(K1, 1'b0);
        repeat (2) @(negedge clk);
        key = 64'hDEADBEEFCAFEF00D; key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        chk("gen_ready_c3", {63'b0, key_ready}, 64'd0);
        repeat (6) @(negedge clk);
        key = 64'h0123456789ABCDEF; key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        chk("gen_ready_c10", {63'b0, key_ready}, 64'd0);
        wait_done(n);
        chk("t5_sk0", so[0], SK_FIRST);
        chk("t5_sk15", so[15], SK_LAST);

        accept({$urandom, $urandom}, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_keys_valid", {63'b0, keys_valid}, 64'd0);
        chk("rst_key_ready", {63'b0, key_ready}, 64'd1);
        chk("rst_sk0", so[0], 64'd0);
        chk("rst_sk15", so[15], 64'd0);

        // Hold key_valid across a whole generation so the second key lands on E16+1.
        @(negedge clk);
        key = K1; decrypt = 1'b0; key_valid = 1'b1;
        @(negedge clk);
        key = K1P; decrypt = 1'b1;
        repeat (16) @(negedge clk);
        chk("b2b_valid_e16", {63'b0, keys_valid}, 64'd1);
        chk("b2b_sk0", so[0], SK_FIRST);
        @(negedge clk);
        key_valid = 1'b0;
        chk("b2b_drop", {63'b0, keys_valid}, 64'd0);
        wait_done(n);
        chk("b2b_latency", n, 16);
        chk("b2b_dec_sk0", so[0], SK_LAST);

        for (int it = 0; it < 12; it++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            kr = {$urandom, $urandom};
            accept(kr, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(0, 14)) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                repeat ($urandom_range(1, 12)) @(negedge clk);
                key = {$urandom, $urandom}; key_valid = 1'b1;
                @(negedge clk);
                key_valid = 1'b0;
                wait_done(n);
            end
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
